// File: rtl/hpsdr_ep6_framer.sv
// hpsdr_ep6_framer
//   Builds the HPSDR protocol-1 EP6 UDP payload (1032 bytes): Metis header,
//   32-bit sequence number, then two USB frames of sync + C&C status + 504
//   sample bytes each. The payload is streamed one byte per cycle to the UDP
//   transmitter under its request/enable/active handshake.
//
//   Build option: EP6_SEQ_CLEAR_EN -- when defined, a rising edge of run
//   clears the sequence number (the clear wins over a same-cycle increment).
//
// Ports
//   tx_clock, Tx_reset_n        clock / synchronous active-low reset
//   run                         host streaming enable
//   fifo_rddata, fifo_rdused    show-ahead sample FIFO data and fill level
//   fifo_rdreq                  pop one sample byte
//   ptt_i, dot_i, dash_i        key/PTT status reported in C0
//   adc_overload                ADC overload reported at C&C address 0
//   exc_pwr, fwd_pwr,
//   rev_pwr, pa_volt            analog readings reported at C&C addresses 1, 2
//   udp_tx_request/_length      payload request and constant length
//   udp_tx_enable               one-cycle grant from the network
//   udp_tx_active               network takes one byte per cycle while high
//   udp_tx_data                 payload byte
module hpsdr_ep6_framer #(
    parameter int unsigned PAYLOAD_LEN = 1032,
    parameter int unsigned FRAME_DATA  = 504,
    parameter logic [7:0]  FW_VERSION  = 8'd73
) (
    input  logic        tx_clock,
    input  logic        Tx_reset_n,
    input  logic        run,
    input  logic [7:0]  fifo_rddata,
    input  logic [10:0] fifo_rdused,
    output logic        fifo_rdreq,
    input  logic        ptt_i,
    input  logic        dot_i,
    input  logic        dash_i,
    input  logic        adc_overload,
    input  logic [11:0] exc_pwr,
    input  logic [11:0] fwd_pwr,
    input  logic [11:0] rev_pwr,
    input  logic [11:0] pa_volt,
    output logic        udp_tx_request,
    output logic [10:0] udp_tx_length,
    input  logic        udp_tx_enable,
    input  logic        udp_tx_active,
    output logic [7:0]  udp_tx_data
);

    // Byte positions inside the payload: each frame is 3 sync + 5 C&C bytes
    // followed by FRAME_DATA sample bytes.
    localparam logic [10:0] F0_SYNC  = 11'd8;
    localparam logic [10:0] F0_DATA  = 11'd16;
    localparam logic [10:0] F1_SYNC  = F0_DATA + 11'(FRAME_DATA);
    localparam logic [10:0] F1_DATA  = F1_SYNC + 11'd8;
    localparam logic [10:0] LAST     = 11'(PAYLOAD_LEN - 1);
    localparam logic [10:0] FILL_MIN = 11'(2 * FRAME_DATA);

    typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;

    state_t      state_q, state_d;
    logic        udp_tx_request_q, udp_tx_request_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] seq_q, seq_d;
    logic [1:0]  cc_addr_q, cc_addr_d;
    logic [39:0] cc_q, cc_d;           // {C0, C1, C2, C3, C4} of the current frame
`ifdef EP6_SEQ_CLEAR_EN
    logic        run_d_q, run_d_d;
`endif

    logic        in_data;
    logic        in_f1_hdr;
    logic [2:0]  hdr_off;
    logic [7:0]  data_byte;

    // C&C status bytes for one frame, packed as {C0, C1, C2, C3, C4}.
    function automatic logic [39:0] cc_word(
        input logic [1:0]  addr,
        input logic        dot, dash, ptt, ovl,
        input logic [11:0] exc, fwd, rev, pav
    );
        logic [7:0] c0;
        c0 = {3'b000, addr, dot, dash, ptt};
        case (addr)
            2'd0:    cc_word = {c0, 7'b0, ovl, FW_VERSION, 16'h0000};
            2'd1:    cc_word = {c0, 4'b0, exc, 4'b0, fwd};
            2'd2:    cc_word = {c0, 4'b0, rev, 4'b0, pav};
            default: cc_word = {c0, 32'h0000_0000};
        endcase
    endfunction

    assign in_data   = ((byte_cnt_q >= F0_DATA) && (byte_cnt_q < F1_SYNC)) ||
                       ((byte_cnt_q >= F1_DATA) && (byte_cnt_q <= LAST));
    assign in_f1_hdr = (byte_cnt_q >= F1_SYNC) && (byte_cnt_q < F1_DATA);
    assign hdr_off   = in_f1_hdr ? 3'(byte_cnt_q - F1_SYNC) : 3'(byte_cnt_q - F0_SYNC);

    always_comb begin
        data_byte = 8'h00;
        if (byte_cnt_q < 11'd4) begin
            case (byte_cnt_q[1:0])
                2'd0:    data_byte = 8'hEF;
                2'd1:    data_byte = 8'hFE;
                2'd2:    data_byte = 8'h01;
                default: data_byte = 8'h06;
            endcase
        end else if (byte_cnt_q < F0_SYNC) begin
            case (byte_cnt_q[1:0])
                2'd0:    data_byte = seq_q[31:24];
                2'd1:    data_byte = seq_q[23:16];
                2'd2:    data_byte = seq_q[15:8];
                default: data_byte = seq_q[7:0];
            endcase
        end else if (in_data) begin
            data_byte = fifo_rddata;
        end else begin
            case (hdr_off)
                3'd0, 3'd1, 3'd2: data_byte = 8'h7F;
                3'd3:             data_byte = cc_q[39:32];
                3'd4:             data_byte = cc_q[31:24];
                3'd5:             data_byte = cc_q[23:16];
                3'd6:             data_byte = cc_q[15:8];
                default:          data_byte = cc_q[7:0];
            endcase
        end
    end

    assign fifo_rdreq     = (state_q == SEND) && udp_tx_active && in_data;
    assign udp_tx_data    = (state_q == SEND) ? data_byte : 8'h00;
    assign udp_tx_request = udp_tx_request_q;
    assign udp_tx_length  = 11'(PAYLOAD_LEN);

    always_comb begin
        state_d          = state_q;
        udp_tx_request_d = udp_tx_request_q;
        byte_cnt_d       = byte_cnt_q;
        seq_d            = seq_q;
        cc_addr_d        = cc_addr_q;
        cc_d             = cc_q;
        case (state_q)
            IDLE: begin
                if (run && (fifo_rdused >= FILL_MIN)) begin
                    state_d          = REQ;
                    udp_tx_request_d = 1'b1;
                end
            end
            REQ: begin
                // Once requested, the packet always completes even if run drops.
                if (udp_tx_enable) begin
                    state_d          = SEND;
                    udp_tx_request_d = 1'b0;
                    byte_cnt_d       = 11'd0;
                end
            end
            SEND: begin
                if (udp_tx_active) begin
                    byte_cnt_d = byte_cnt_q + 11'd1;
                    // Status inputs are snapshotted on the first sync byte of
                    // each frame so the five C&C bytes are self-consistent.
                    if (byte_cnt_q == F0_SYNC)
                        cc_d = cc_word(cc_addr_q, dot_i, dash_i, ptt_i, adc_overload,
                                       exc_pwr, fwd_pwr, rev_pwr, pa_volt);
                    else if (byte_cnt_q == F1_SYNC)
                        cc_d = cc_word(cc_addr_q + 2'd1, dot_i, dash_i, ptt_i, adc_overload,
                                       exc_pwr, fwd_pwr, rev_pwr, pa_volt);
                    if (byte_cnt_q == LAST)
                        state_d = DONE;
                end
            end
            DONE: begin
                seq_d     = seq_q + 32'd1;
                cc_addr_d = cc_addr_q + 2'd2;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef EP6_SEQ_CLEAR_EN
        run_d_d = run;
        if (run && !run_d_q)
            seq_d = 32'd0;
`endif
    end

    always_ff @(posedge tx_clock) begin
        if (!Tx_reset_n) begin
            state_q          <= IDLE;
            udp_tx_request_q <= 1'b0;
            byte_cnt_q       <= 11'd0;
            seq_q            <= 32'd0;
            cc_addr_q        <= 2'd0;
`ifdef EP6_SEQ_CLEAR_EN
            run_d_q          <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            udp_tx_request_q <= udp_tx_request_d;
            byte_cnt_q       <= byte_cnt_d;
            seq_q            <= seq_d;
            cc_addr_q        <= cc_addr_d;
`ifdef EP6_SEQ_CLEAR_EN
            run_d_q          <= run_d_d;
`endif
        end
    end

    // C&C snapshot is pure data and needs no reset.
    always_ff @(posedge tx_clock) begin
        cc_q <= cc_d;
    end

endmodule

// File: doc/hpsdr_ep6_framer.md
Name: hpsdr_ep6_framer

Overview:
Builds the HPSDR protocol-1 EP6 UDP payload that carries radio samples back to the host. It is the transmit-direction counterpart to the received-command path.
- Pulls sample bytes from the Tx sample FIFO.
- Inserts the Metis header, a 32-bit sequence number, two 512-byte USB frames with sync and rotating C&C status bytes.
- Streams the 1032-byte payload to the network UDP transmitter byte-per-cycle under the request/enable/active handshake.

Parameters:
PAYLOAD_LEN, 1032, UDP payload length in bytes (driven on udp_tx_length)
FRAME_DATA, 504, sample bytes per USB frame
FW_VERSION, 8'd73, firmware version reported in C&C address 0

Ports:
tx_clock  in  1  ethernet transmit clock; all logic in this domain
Tx_reset_n  in  1  synchronous, active-low reset
run  in  1  host has enabled streaming
fifo_rddata  in  8  sample FIFO show-ahead data
fifo_rdused  in  11  sample FIFO fill level, bytes
fifo_rdreq  out  1  pop one byte from the sample FIFO
ptt_i, dot_i, dash_i  in  1 each  key/PTT status bits
adc_overload  in  1  ADC overload flag
exc_pwr, fwd_pwr, rev_pwr, pa_volt  in  12 each  analog readings
udp_tx_request  out  1  payload ready, requesting the network transmitter
udp_tx_length  out  11  payload length
udp_tx_enable  in  1  one-cycle grant from the network
udp_tx_active  in  1  network consumes one byte per cycle while high
udp_tx_data  out  8  payload byte

Behaviour:
- Reset (Tx_reset_n=0 at a tx_clock edge) values: state=IDLE; udp_tx_request=0; fifo_rdreq=0; udp_tx_data=0; seq=0; cc_addr=0; byte_cnt=0.
- udp_tx_length is the constant PAYLOAD_LEN at all times, including reset.
- States:
  - IDLE: move to REQ when run=1 and fifo_rdused >= 2*FRAME_DATA (1008).
  - REQ: hold udp_tx_request=1. On udp_tx_enable=1: drop the request next cycle, clear byte_cnt, move to SEND.
  - SEND: each cycle with udp_tx_active=1, drive the byte selected by byte_cnt combinationally from byte_cnt, then increment byte_cnt. After byte 1031 is consumed, move to DONE.
  - DONE: seq += 1 (wraps 0xFFFFFFFF -> 0), then IDLE.
- If udp_tx_active is low while in SEND, the block stalls: byte_cnt holds and fifo_rdreq=0.
- Byte map:
  - 0-3: EF FE 01 06.
  - 4-7: seq, big-endian.
  - 8-10: 7F 7F 7F.
  - 11-15: C0-C4 for cc_addr.
  - 16-519: FIFO data.
  - 520-522: 7F 7F 7F.
  - 523-527: C0-C4 for cc_addr+1.
  - 528-1031: FIFO data.
- fifo_rdreq = SEND & udp_tx_active & byte_cnt in a data region. udp_tx_data = fifo_rddata in the same cycle (show-ahead). Exactly 1008 pops per packet.
- C&C bytes:
  - C0 = {addr[4:0]<<3 | dot_i<<2 | dash_i<<1 | ptt_i}; addr 0..3 encodes as C0[4:3].
  - Addr 0: C1={7'b0,adc_overload}, C2=FW_VERSION, C3=0, C4=0.
  - Addr 1: C1C2={4'b0,exc_pwr}, C3C4={4'b0,fwd_pwr}.
  - Addr 2: C1C2=rev_pwr, C3C4=pa_volt.
  - Addr 3: all zero.
  - C&C inputs are sampled at the first byte of their frame (bytes 8 and 520) and held for the frame.
  - cc_addr advances by 2 mod 4 per packet, so the frames of one packet carry consecutive addresses.
- Boundaries:
  - run falling during REQ or SEND: the packet completes and the sequence increments; no new request follows.
  - udp_tx_enable outside REQ is ignored.
  - fifo_rdused exactly 1008 qualifies; 1007 does not.
  - Reset mid-SEND aborts the packet and returns to IDLE with seq=0.

Optional Feature:
EP6_SEQ_CLEAR_EN
- Defined: a rising edge of run (registered run_d) clears seq to 0. If the edge coincides with the DONE increment, the clear wins.
- Undefined: seq is free-running and is cleared only by Tx_reset_n.

Test Plan:
- Reset, run=1, fifo_rdused=1008, grant 3 cycles after request, udp_tx_active high for 1032 cycles -> bytes 0-15 = EF FE 01 06 00 00 00 00 7F 7F 7F 00|ptt… ; 1008 fifo_rdreq pulses; seq=1 afterwards.
- fifo_rdused=1007 with run=1 -> udp_tx_request stays 0 for 100 cycles; raise to 1008 -> request asserts within 2 cycles.
- Toggle udp_tx_active low for 5 cycles at byte 300 -> no pops, byte_cnt frozen, output stream resumes with the correct byte.
- Three back-to-back packets, fwd_pwr=12'hABC -> C0 addresses 0,1 / 2,3 / 0,1. In address-1 frames, C3=0A and C4=BC.
- Preload seq=0xFFFFFFFF, send a packet -> bytes 4-7 = FF FF FF FF; next packet bytes 4-7 = 00 00 00 00.
- Assert Tx_reset_n=0 at byte 600 -> outputs at reset values next cycle; restart gives a packet with seq=0. With EP6_SEQ_CLEAR_EN, run toggling 1->0->1 after 5 packets -> next seq=0.
